// File: rtl/preemph.sv
// FM transmit pre-emphasis: y[n] = (B0*x[n] + B1*x[n-1]) / 2^QUANT_BITS.
// Reads from an upstream FWFT FIFO and writes to a downstream FIFO, one sample per 3 cycles at best.
module preemph #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUANT_BITS  = 10,
    parameter int COEFF_WIDTH = 16,
    parameter int B0          = 2943,
    parameter int B1          = -1919
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

    localparam logic signed [COEFF_WIDTH-1:0] B0_C = COEFF_WIDTH'(B0);
    localparam logic signed [COEFF_WIDTH-1:0] B1_C = COEFF_WIDTH'(B1);
    localparam logic signed [PROD_WIDTH:0] NEG_BIAS = (PROD_WIDTH+1)'((1 << QUANT_BITS) - 1);

    typedef enum logic [1:0] {
        S_READ,
        S_MULT,
        S_WRITE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0]        x_reg;
    logic [DATA_WIDTH-1:0]        x_prev;
    logic signed [PROD_WIDTH-1:0] prod0;
    logic signed [PROD_WIDTH-1:0] prod1;
    logic signed [PROD_WIDTH-1:0] mult0;
    logic signed [PROD_WIDTH-1:0] mult1;
    logic signed [PROD_WIDTH:0]   sum;
    logic signed [PROD_WIDTH:0]   biased;

    assign mult0 = PROD_WIDTH'($signed(x_reg)) * PROD_WIDTH'(B0_C);
    assign mult1 = PROD_WIDTH'($signed(x_prev)) * PROD_WIDTH'(B1_C);

    // Negative sums get a bias of 2^Q-1 so the arithmetic shift truncates toward zero.
    assign sum     = (PROD_WIDTH+1)'(prod0) + (PROD_WIDTH+1)'(prod1);
    assign biased  = sum + (sum[PROD_WIDTH] ? NEG_BIAS : '0);
    assign out_din = DATA_WIDTH'(biased >>> QUANT_BITS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_READ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state)
            S_READ: begin
                if (!in_empty && !reset) begin
                    in_rd_en   = 1'b1;
                    state_next = S_MULT;
                end
            end
            S_MULT: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full && !reset) begin
                    out_wr_en  = 1'b1;
                    state_next = S_READ;
                end
            end
            default: begin
                state_next = S_READ;
            end
        endcase
    end

    // Products stay registered through S_WRITE so out_din is held steady while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_reg  <= '0;
            x_prev <= '0;
            prod0  <= '0;
            prod1  <= '0;
        end else begin
            if (in_rd_en) begin
                x_reg <= in_dout;
            end
            if (state == S_MULT) begin
                prod0 <= mult0;
                prod1 <= mult1;
            end
            if (out_wr_en) begin
                x_prev <= x_reg;
            end
        end
    end

endmodule

// File: tb/tb_preemph.sv
// Scoreboard bench for preemph: a FWFT FIFO model feeds the DUT and a monitor checks every write.
module tb_preemph;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_dout = '0;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [31:0] out_din;
    logic        out_full = 1'b0;
    logic        out_wr_en;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int pop_count = 0;
    int last_pop_cycle = 0;
    int last_write = -1;
    bit check_lat = 1'b1;

    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_prev = '0;

    preemph #(
        .DATA_WIDTH (32),
        .QUANT_BITS (10),
        .COEFF_WIDTH(16),
        .B0         (2943),
        .B1         (-1919)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .out_din  (out_din),
        .out_full (out_full),
        .out_wr_en(out_wr_en)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task refresh_in;
        in_empty = (in_q.size() == 0);
        in_dout  = in_empty ? 32'h0 : in_q[0];
    endtask

    // Reference: exact integer arithmetic, signed division truncates toward zero.
    function automatic logic [31:0] model_y(input logic [31:0] x, input logic [31:0] xp);
        longint acc;
        longint q;
        acc = longint'($signed(x)) * 2943 + longint'($signed(xp)) * (-1919);
        q   = acc / 1024;
        return q[31:0];
    endfunction

    // Upstream FWFT FIFO model and cycle bookkeeping
    always @(posedge clock) begin
        cycle++;
        if (in_rd_en && in_q.size() > 0) begin
            void'(in_q.pop_front());
            pop_count++;
            last_pop_cycle = cycle;
        end
    end

    always begin
        @(posedge clock);
        #2;
        refresh_in();
    end

    // Monitor: the write commits at the next rising edge, labelled cycle+1
    always @(negedge clock) begin
        logic [31:0] expv;
        if (out_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got %h, expected no write", out_din);
            end else begin
                expv = exp_q.pop_front();
                check_output("out_din", out_din, expv);
            end
            if (check_lat) begin
                check_int("latency", cycle + 1 - last_pop_cycle, 2);
            end
            if (last_write >= 0) begin
                checks++;
                if (cycle + 1 - last_write < 3) begin
                    errors++;
                    $display("[TB] FAIL throughput: got gap %0d, expected at least 3", cycle + 1 - last_write);
                end
            end
            last_write = cycle + 1;
        end
    end

    task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] expv, input int gap);
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        in_q.push_back(x);
        exp_q.push_back(expv);
        refresh_in();
    endtask

    task automatic apply_model_stimulus(input logic [31:0] x, input int gap);
        logic [31:0] expv;
        expv   = model_y(x, m_prev);
        m_prev = x;
        apply_stimulus(x, expv, gap);
    endtask

    // Asserts reset immediately; a word is left in the FIFO to prove pops are gated.
    task automatic do_reset;
        reset = 1'b1;
        in_q.delete();
        exp_q.delete();
        in_q.push_back(32'h0000_1234);
        refresh_in();
        out_full = 1'b0;
        #1;
        check_output("rst_in_rd_en", {31'b0, in_rd_en}, 32'h0);
        check_output("rst_out_wr_en", {31'b0, out_wr_en}, 32'h0);
        check_output("rst_out_din", out_din, 32'h0);
        @(posedge clock);
        #1;
        in_q.delete();
        refresh_in();
        m_prev = '0;
        last_write = -1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        repeat (4) @(posedge clock);
        #1;
        check_int({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        @(posedge clock);
        #1;

        // Impulse response
        do_reset();
        apply_stimulus(32'h0000_0400, 32'h0000_0B7F, 0);
        apply_stimulus(32'h0000_0000, 32'hFFFF_F881, 0);
        apply_stimulus(32'h0000_0000, 32'h0000_0000, 0);
        wait_drain("impulse", 100);

        // Step response: DC gain of one
        do_reset();
        apply_stimulus(32'h0000_0400, 32'h0000_0B7F, 0);
        apply_stimulus(32'h0000_0400, 32'h0000_0400, 0);
        apply_stimulus(32'h0000_0400, 32'h0000_0400, 0);
        wait_drain("step", 100);

        // Negative result truncates toward zero
        do_reset();
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        wait_drain("neg_trunc", 100);

        // Backpressure: 20 stalled cycles with 4 samples queued
        do_reset();
        out_full  = 1'b1;
        check_lat = 1'b0;
        base      = pop_count;
        apply_stimulus(32'h0000_0400, 32'h0000_0B7F, 0);
        apply_stimulus(32'h0000_0800, 32'h0000_0F7F, 0);
        apply_stimulus(32'hFFFF_FE00, 32'hFFFF_EB43, 0);
        apply_stimulus(32'h0000_0000, 32'h0000_03BF, 0);
        repeat (20) begin
            @(negedge clock);
            check_output("stall_out_wr_en", {31'b0, out_wr_en}, 32'h0);
            if (pop_count - base >= 1) begin
                check_output("stall_in_rd_en", {31'b0, in_rd_en}, 32'h0);
            end
        end
        check_int("stall_pops", pop_count - base, 1);
        @(posedge clock);
        #1;
        out_full = 1'b0;
        wait_drain("backpressure", 200);
        check_lat = 1'b1;

        // Random bubbles, including wrap-around extremes
        do_reset();
        apply_model_stimulus(32'h7FFF_FFFF, 0);
        apply_model_stimulus(32'h8000_0000, 0);
        apply_model_stimulus(32'h8000_0000, 0);
        for (int i = 0; i < 61; i++) begin
            apply_model_stimulus($urandom, $urandom_range(0, 7));
        end
        apply_model_stimulus(32'h0000_0001, 0);
        wait_drain("bubbles", 2000);

        // Reset while the sixth sample is in S_MULT
        do_reset();
        base = pop_count;
        apply_stimulus(32'h0000_0400, 32'h0000_0B7F, 0);
        apply_stimulus(32'h0000_0000, 32'hFFFF_F881, 0);
        apply_stimulus(32'h0000_0000, 32'h0000_0000, 0);
        apply_stimulus(32'h0000_0400, 32'h0000_0B7F, 0);
        apply_stimulus(32'h0000_0400, 32'h0000_0400, 0);
        in_q.push_back(32'h0000_0800);
        refresh_in();
        n = 0;
        while (pop_count - base < 6 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_int("midstream_pops", pop_count - base, 6);
        check_int("midstream_outputs", exp_q.size(), 0);
        do_reset();
        apply_stimulus(32'h0000_0400, 32'h0000_0B7F, 0);
        wait_drain("midstream_reset", 100);
        repeat (10) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
